pe_col_ctrl: RTL and testbench



---
 rtl/pe_col_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pe_col_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_ctrl.sv
// pe_col_ctrl: column sequencer that steps a PE column through 3x3/5x5 kernel passes,
// one accepted activation beat per step, gating each output group on PE FIFO space.

package pe_col_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        S5   = 3'd5
    } PE_state_t;

    typedef enum logic [2:0] {
        E_MODE = 3'd0,
        A_MODE = 3'd1,
        B_MODE = 3'd2,
        C_MODE = 3'd3,
        D_MODE = 3'd4
    } PE_weight_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_t;
endpackage

module pe_col_ctrl
    import pe_col_pkg::*;
#(
    parameter int NUM_PE = 8,
    parameter int GRP_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_k5,
    input  logic             cfg_bit_mode,
    input  logic [GRP_W-1:0] cfg_groups,
    input  logic [ROW_W-1:0] cfg_rows,
    input  logic             act_valid_i,
    output logic             act_ready_o,
    input  logic [NUM_PE-1:0] pe_fifo_full_i,
    output PE_state_t        pe_state_o,
    output PE_weight_mode_t  pe_weight_mode_o,
    output logic             pe_finish_o,
    output logic             pe_end_of_row_o,
    output logic             pe_bit_mode_o,
    output logic [2:0]       weight_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output fsm_state_t       fsm_state_o
);

    // Handshake: a beat is consumed in any cycle where act_valid_i && act_ready_o;
    // act_ready_o depends only on the FSM state, never on act_valid_i.

    fsm_state_t       fsm_q, fsm_d;
    logic [2:0]       step_q, step_d;
    logic [GRP_W-1:0] group_q, group_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [GRP_W-1:0] groups_q;
    logic [ROW_W-1:0] rows_q;
    logic             k5_q;
    logic             bit_mode_q;
    logic [2:0]       idx_q;
    logic             busy_q;
    logic             done_q;
    logic             latch_cfg;
    logic [2:0]       last_step;

    always_comb begin
        fsm_d            = fsm_q;
        step_d           = step_q;
        group_d          = group_q;
        row_d            = row_q;
        latch_cfg        = 1'b0;
        act_ready_o      = 1'b0;
        pe_state_o       = IDLE;
        pe_weight_mode_o = E_MODE;
        pe_finish_o      = 1'b0;
        pe_end_of_row_o  = 1'b0;
        last_step        = k5_q ? 3'd5 : 3'd3;

        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    if (cfg_groups == '0 || cfg_rows == '0) begin
                        fsm_d = ST_DONE;
                    end else begin
                        fsm_d   = ST_GATE;
                        step_d  = 3'd1;
                        group_d = '0;
                        row_d   = '0;
                    end
                end
            end

            ST_GATE: begin
                if (!(|pe_fifo_full_i)) fsm_d = ST_RUN;
            end

            ST_RUN: begin
                act_ready_o = 1'b1;
                if (k5_q) begin
                    case (step_q)
                        3'd1, 3'd2: pe_weight_mode_o = A_MODE;
                        3'd3:       pe_weight_mode_o = B_MODE;
                        3'd4:       pe_weight_mode_o = C_MODE;
                        3'd5:       pe_weight_mode_o = D_MODE;
                        default:    pe_weight_mode_o = E_MODE;
                    endcase
                end
                // Without a beat the PEs see IDLE so their partial sums hold.
                if (act_valid_i) begin
                    pe_state_o = PE_state_t'(step_q);
                    if (step_q == last_step) begin
                        pe_finish_o = 1'b1;
                        step_d      = 3'd1;
                        if (group_q == groups_q - 1'b1) begin
                            pe_end_of_row_o = 1'b1;
                            group_d         = '0;
                            row_d           = row_q + 1'b1;
                            fsm_d = (row_q == rows_q - 1'b1) ? ST_DONE : ST_GATE;
                        end else begin
                            group_d = group_q + 1'b1;
                            fsm_d   = ST_GATE;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end

            ST_DONE: fsm_d = ST_IDLE;

            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            step_q     <= '0;
            group_q    <= '0;
            row_q      <= '0;
            groups_q   <= '0;
            rows_q     <= '0;
            k5_q       <= 1'b0;
            bit_mode_q <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            step_q  <= step_d;
            group_q <= group_d;
            row_q   <= row_d;
            if (latch_cfg) begin
                groups_q   <= cfg_groups;
                rows_q     <= cfg_rows;
                k5_q       <= cfg_k5;
                bit_mode_q <= cfg_bit_mode;
            end
            // Weight slice tracks the step that will be presented next cycle.
            idx_q  <= (step_d == 3'd0) ? 3'd0 : step_d - 3'd1;
            busy_q <= (fsm_d != ST_IDLE);
            done_q <= (fsm_d == ST_DONE);
        end
    end

    assign pe_bit_mode_o = bit_mode_q;
    assign weight_idx_o  = idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fsm_state_o   = fsm_q;

endmodule

// File: tb/tb_pe_col_ctrl.sv
// Bench for pe_col_ctrl: directed layers, expected beat/done records queued at issue
// and popped by a negedge monitor, plus cycle-exact checks in the stimulus thread.

module tb_pe_col_ctrl;
    import pe_col_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            cfg_k5;
    logic            cfg_bit_mode;
    logic [7:0]      cfg_groups;
    logic [7:0]      cfg_rows;
    logic            act_valid_i;
    logic            act_ready_o;
    logic [7:0]      pe_fifo_full_i;
    PE_state_t       pe_state_o;
    PE_weight_mode_t pe_weight_mode_o;
    logic            pe_finish_o;
    logic            pe_end_of_row_o;
    logic            pe_bit_mode_o;
    logic [2:0]      weight_idx_o;
    logic            busy_o;
    logic            done_o;
    fsm_state_t      fsm_state_o;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [11:0] exp_q[$];

    pe_col_ctrl #(.NUM_PE(8), .GRP_W(8), .ROW_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_k5           (cfg_k5),
        .cfg_bit_mode     (cfg_bit_mode),
        .cfg_groups       (cfg_groups),
        .cfg_rows         (cfg_rows),
        .act_valid_i      (act_valid_i),
        .act_ready_o      (act_ready_o),
        .pe_fifo_full_i   (pe_fifo_full_i),
        .pe_state_o       (pe_state_o),
        .pe_weight_mode_o (pe_weight_mode_o),
        .pe_finish_o      (pe_finish_o),
        .pe_end_of_row_o  (pe_end_of_row_o),
        .pe_bit_mode_o    (pe_bit_mode_o),
        .weight_idx_o     (weight_idx_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .fsm_state_o      (fsm_state_o)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    function automatic logic [11:0] pack(input logic [2:0] st, input logic [2:0] md,
                                         input logic [2:0] idx, input logic fin,
                                         input logic eor, input logic dn);
        return {dn, eor, fin, idx, md, st};
    endfunction

    task automatic push_beat(input logic [2:0] st, input logic [2:0] md, input logic [2:0] idx,
                             input logic fin, input logic eor);
        exp_q.push_back(pack(st, md, idx, fin, eor, 1'b0));
    endtask

    task automatic push_done();
        exp_q.push_back(pack(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic push_group3(input logic eor);
        push_beat(3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
        push_beat(3'd2, 3'd0, 3'd1, 1'b0, 1'b0);
        push_beat(3'd3, 3'd0, 3'd2, 1'b1, eor);
    endtask

    task automatic push_group5(input logic eor);
        push_beat(3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
        push_beat(3'd2, 3'd1, 3'd1, 1'b0, 1'b0);
        push_beat(3'd3, 3'd2, 3'd2, 1'b0, 1'b0);
        push_beat(3'd4, 3'd3, 3'd3, 1'b0, 1'b0);
        push_beat(3'd5, 3'd4, 3'd4, 1'b1, eor);
    endtask

    // Monitor: every presented beat, finish, end-of-row or done pops one record.
    always @(negedge clk) begin
        if (mon_en && (pe_state_o != IDLE || done_o || pe_finish_o || pe_end_of_row_o)) begin
            logic [11:0] got;
            logic [11:0] exp;
            got = pack(3'(pe_state_o), 3'(pe_weight_mode_o), weight_idx_o,
                       pe_finish_o, pe_end_of_row_o, done_o);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected actual=%03h required=none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL mon_record actual=%03h required=%03h", got, exp);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse; returns inside the cycle after the pulse.
    task automatic do_start(input logic k5, input logic bm, input logic [7:0] g, input logic [7:0] r);
        start        = 1'b1;
        cfg_k5       = k5;
        cfg_bit_mode = bm;
        cfg_groups   = g;
        cfg_rows     = r;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, budget);
        end
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] st_seq[9];
        logic       vseq[5];
        logic [2:0] tseq[5];
        int         done_seen;

        rst = 1'b1; start = 1'b0; cfg_k5 = 1'b0; cfg_bit_mode = 1'b0;
        cfg_groups = '0; cfg_rows = '0; act_valid_i = 1'b0; pe_fifo_full_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 8'(act_ready_o), 8'd0);
        chk("rst_state", 8'(pe_state_o), 8'd0);
        chk("rst_mode", 8'(pe_weight_mode_o), 8'd0);
        chk("rst_finish", 8'(pe_finish_o), 8'd0);
        chk("rst_eor", 8'(pe_end_of_row_o), 8'd0);
        chk("rst_bitmode", 8'(pe_bit_mode_o), 8'd0);
        chk("rst_idx", 8'(weight_idx_o), 8'd0);
        chk("rst_busy", 8'(busy_o), 8'd0);
        chk("rst_done", 8'(done_o), 8'd0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // 3x3, 2 groups, 1 row, valid held high: cycle-exact state trace
        st_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        push_group3(1'b0);
        push_group3(1'b1);
        push_done();
        act_valid_i = 1'b1;
        do_start(1'b0, 1'b0, 8'd2, 8'd1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("t1_state_t%0d", i), 8'(pe_state_o), 8'(st_seq[i-1]));
            chk($sformatf("t1_fin_t%0d", i), 8'(pe_finish_o), (i == 4 || i == 8) ? 8'd1 : 8'd0);
            chk($sformatf("t1_eor_t%0d", i), 8'(pe_end_of_row_o), (i == 8) ? 8'd1 : 8'd0);
            chk($sformatf("t1_done_t%0d", i), 8'(done_o), (i == 9) ? 8'd1 : 8'd0);
            chk($sformatf("t1_busy_t%0d", i), 8'(busy_o), 8'd1);
            if (i == 1) chk("t1_gate_ready", 8'(act_ready_o), 8'd0);
            if (i == 2) chk("t1_run_ready", 8'(act_ready_o), 8'd1);
            tick();
        end
        @(negedge clk);
        chk("t1_busy_after_done", 8'(busy_o), 8'd0);
        chk_drained("t1");
        tick();

        // 5x5, 1 group, 2 rows, bit mode on; a second start mid-layer must be ignored
        push_group5(1'b1);
        push_group5(1'b1);
        push_done();
        do_start(1'b1, 1'b1, 8'd1, 8'd2);
        tick();
        tick();
        start = 1'b1; cfg_k5 = 1'b0; cfg_bit_mode = 1'b0; cfg_groups = 8'd7; cfg_rows = 8'd3;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t2_bitmode", 8'(pe_bit_mode_o), 8'd1);
        wait_done(40, "t2");
        tick();
        @(negedge clk);
        chk("t2_busy_after_done", 8'(busy_o), 8'd0);
        chk_drained("t2");
        tick();

        // FIFO full held through GATE; mid-group full does not stall
        push_group3(1'b1);
        push_done();
        pe_fifo_full_i = 8'h04;
        do_start(1'b0, 1'b0, 8'd1, 8'd1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_ready_%0d", i), 8'(act_ready_o), 8'd0);
            chk($sformatf("t3_hold_state_%0d", i), 8'(pe_state_o), 8'd0);
            tick();
        end
        pe_fifo_full_i = 8'h00;
        @(negedge clk);
        chk("t3_clear_cycle_ready", 8'(act_ready_o), 8'd0);
        tick();
        @(negedge clk);
        chk("t3_run_ready", 8'(act_ready_o), 8'd1);
        chk("t3_run_state", 8'(pe_state_o), 8'd1);
        tick();
        pe_fifo_full_i = 8'h80;
        wait_done(10, "t3");
        pe_fifo_full_i = 8'h00;
        tick();
        chk_drained("t3");

        // Valid toggling inside a 3x3 group
        push_group3(1'b1);
        push_done();
        act_valid_i = 1'b0;
        vseq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tseq = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd3};
        do_start(1'b0, 1'b0, 8'd1, 8'd1);
        @(negedge clk);
        chk("t4_gate_state", 8'(pe_state_o), 8'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            act_valid_i = vseq[i];
            @(negedge clk);
            chk($sformatf("t4_state_%0d", i), 8'(pe_state_o), 8'(tseq[i]));
            chk($sformatf("t4_fin_%0d", i), 8'(pe_finish_o), (i == 4) ? 8'd1 : 8'd0);
            tick();
        end
        act_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_done", 8'(done_o), 8'd1);
        tick();
        chk_drained("t4");

        // Zero rows: immediate done, no beats; start during the done window ignored
        push_done();
        act_valid_i = 1'b1;
        done_seen = 0;
        do_start(1'b0, 1'b0, 8'd3, 8'd0);
        start = 1'b1; cfg_groups = 8'd1; cfg_rows = 8'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_o) done_seen++;
            chk($sformatf("t5_ready_%0d", i), 8'(act_ready_o), 8'd0);
            tick();
            start = 1'b0;
        end
        chk("t5_done_count", 8'(done_seen), 8'd1);
        @(negedge clk);
        chk("t5_busy", 8'(busy_o), 8'd0);
        chk_drained("t5");
        tick();

        // Reset on the second beat of a 5x5 group, then a clean restart
        push_beat(3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
        push_beat(3'd2, 3'd1, 3'd1, 1'b0, 1'b0);
        do_start(1'b1, 1'b1, 8'd1, 8'd1);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready", 8'(act_ready_o), 8'd0);
        chk("t6_state", 8'(pe_state_o), 8'd0);
        chk("t6_mode", 8'(pe_weight_mode_o), 8'd0);
        chk("t6_finish", 8'(pe_finish_o), 8'd0);
        chk("t6_eor", 8'(pe_end_of_row_o), 8'd0);
        chk("t6_bitmode", 8'(pe_bit_mode_o), 8'd0);
        chk("t6_idx", 8'(weight_idx_o), 8'd0);
        chk("t6_busy", 8'(busy_o), 8'd0);
        chk("t6_done", 8'(done_o), 8'd0);
        repeat (5) tick();
        chk_drained("t6_abort");
        push_group5(1'b1);
        push_done();
        do_start(1'b1, 1'b0, 8'd1, 8'd1);
        wait_done(20, "t6_restart");
        tick();
        tick();
        chk_drained("t6_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
